// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner:
// FSM state encoding and the counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Width for a counter that must reach n-1; never narrower than one bit.
  function automatic int BTN_CNT_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL sets the level both flops take while rst_n is low.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit press/release/long pulses
// plus a wrapping press count. Define BTN_LONG_PRESS_EN to build the long-press logic.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int LONG_CYCLES     = 6000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output logic [3:0] press_count_o
);

  localparam int              DB_W    = BTN_CNT_W(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_badParams
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2 and below LONG_CYCLES");
  end

  logic            w_pinSync;
  logic            w_s;
  btn_state_t      r_state;
  btn_state_t      w_stateNext;
  logic [DB_W-1:0] r_dbCnt;
  logic [DB_W-1:0] w_dbCntNext;
  logic            w_pressNext;
  logic            w_releaseNext;
  logic            r_level;
  logic            r_press;
  logic            r_release;
  logic [3:0]      r_count;

  // Reset to the released pin level so reset never looks like a press.
  sync2 #(.RESET_VAL(ACTIVE_LOW)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (btn_i),
    .o_q   (w_pinSync)
  );

  assign w_s = w_pinSync ^ ACTIVE_LOW;

  always_comb begin
    w_stateNext   = r_state;
    w_dbCntNext   = r_dbCnt;
    w_pressNext   = 1'b0;
    w_releaseNext = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_s) begin
          w_stateNext = PRESS_WAIT;
          w_dbCntNext = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_stateNext = RELEASED;
        end else if (r_dbCnt == DB_LAST) begin
          w_stateNext = PRESSED;
          w_pressNext = 1'b1;
        end else begin
          w_dbCntNext = r_dbCnt + DB_ONE;
        end
      end
      PRESSED: begin
        if (!w_s) begin
          w_stateNext = RELEASE_WAIT;
          w_dbCntNext = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_stateNext = PRESSED;
        end else if (r_dbCnt == DB_LAST) begin
          w_stateNext   = RELEASED;
          w_releaseNext = 1'b1;
        end else begin
          w_dbCntNext = r_dbCnt + DB_ONE;
        end
      end
      default: w_stateNext = RELEASED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RELEASED;
      r_dbCnt   <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_count   <= 4'd0;
    end else begin
      r_state   <= w_stateNext;
      r_dbCnt   <= w_dbCntNext;
      r_press   <= w_pressNext;
      r_release <= w_releaseNext;
      if (w_pressNext) begin
        r_level <= 1'b1;
        r_count <= r_count + 4'd1;
      end else if (w_releaseNext) begin
        r_level <= 1'b0;
      end
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int                HOLD_W    = BTN_CNT_W(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [HOLD_W-1:0] r_hold;
  logic              r_longFlag;
  logic              r_long;
  logic              w_longFire;

  assign w_longFire = (r_state == PRESSED) && (r_hold == HOLD_LAST) && !r_longFlag;

  // Hold time survives short release bounces; only an accepted release re-arms the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold     <= '0;
      r_longFlag <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_long <= w_longFire;
      if (w_pressNext) begin
        r_hold <= '0;
      end else if ((r_state == PRESSED) && w_s && (r_hold != HOLD_LAST)) begin
        r_hold <= r_hold + HOLD_ONE;
      end
      if (w_releaseNext) begin
        r_longFlag <= 1'b0;
      end else if (w_longFire) begin
        r_longFlag <= 1'b1;
      end
    end
  end

  assign long_o = r_long;
`else
  assign long_o = 1'b0;
`endif

  assign level_o       = r_level;
  assign press_o       = r_press;
  assign release_o     = r_release;
  assign press_count_o = r_count;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed latency scenarios plus random pin
// activity, all compared against a run-length reference model every cycle.
module tb_btn_debounce;

  localparam int DC = 4;
  localparam int LC = 20;
`ifdef BTN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_i = 1'b1;
  logic       level_o;
  logic       press_o;
  logic       release_o;
  logic       long_o;
  logic [3:0] press_count_o;

  int total = 0;
  int bad = 0;
  int pressSeen = 0;
  int releaseSeen = 0;
  int longSeen = 0;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DC),
    .LONG_CYCLES     (LC),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_i         (btn_i),
    .level_o       (level_o),
    .press_o       (press_o),
    .release_o     (release_o),
    .long_o        (long_o),
    .press_count_o (press_count_o)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the synchronised input has disagreed
  // with the current level for DC+1 consecutive samples.
  typedef struct {
    bit p1, p2, level, flag, press, rel, lng;
    int diffRun, hold, count;
  } model_t;

  model_t mdl;

  function automatic model_t modelReset();
    model_t r;
    r.p1 = 1'b1; r.p2 = 1'b1; r.level = 1'b0; r.flag = 1'b0;
    r.press = 1'b0; r.rel = 1'b0; r.lng = 1'b0;
    r.diffRun = 0; r.hold = 0; r.count = 0;
    return r;
  endfunction

  function automatic model_t modelStep(input model_t m, input bit pin);
    model_t n;
    bit s;
    bit steadyPressed;
    n = m;
    s = !m.p2;
    steadyPressed = m.level && (m.diffRun == 0);
    n.press = 1'b0; n.rel = 1'b0; n.lng = 1'b0;
    if (LONG_EN && steadyPressed && m.hold == LC - 1 && !m.flag) begin
      n.lng = 1'b1;
      n.flag = 1'b1;
    end
    if (steadyPressed && s && m.hold < LC - 1) n.hold = m.hold + 1;
    if (s != m.level) begin
      n.diffRun = m.diffRun + 1;
      if (n.diffRun == DC + 1) begin
        n.level = s;
        n.diffRun = 0;
        if (s) begin
          n.press = 1'b1;
          n.count = (m.count + 1) % 16;
          n.hold = 0;
        end else begin
          n.rel = 1'b1;
          n.flag = 1'b0;
        end
      end
    end else begin
      n.diffRun = 0;
    end
    n.p2 = m.p1;
    n.p1 = pin;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= modelReset();
    else        mdl <= modelStep(mdl, btn_i);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic pin, input int cycles);
    @(negedge clk);
    btn_i = pin;
    repeat (cycles - 1) @(negedge clk);
  endtask

  // Counts rising edges until the selected pulse is seen; -1 if the bound expires.
  task automatic edgesUntil(input int sel, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if ((sel == 0 && press_o) || (sel == 1 && release_o) || (sel == 2 && long_o)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      checkOutput("level", 32'(level_o), 32'(mdl.level));
      checkOutput("press", 32'(press_o), 32'(mdl.press));
      checkOutput("release", 32'(release_o), 32'(mdl.rel));
      checkOutput("long", 32'(long_o), 32'(mdl.lng));
      checkOutput("count", 32'(press_count_o), 32'(mdl.count));
      checkOutput("press_release_excl", 32'(press_o & release_o), 0);
      if (press_o) pressSeen++;
      if (release_o) releaseSeen++;
      if (long_o) longSeen++;
    end
  end

  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int p0, r0, l0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_level", 32'(level_o), 0);
    checkOutput("rst_press", 32'(press_o), 0);
    checkOutput("rst_count", 32'(press_count_o), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_level", 32'(level_o), 0);
    checkOutput("post_rst_long", 32'(long_o), 0);

    $display("[TB] clean press/release");
    applyStimulus(1'b0, 1);
    edgesUntil(0, 20, n);
    checkOutput("clean_press_lat", 32'(n), 7);
    checkOutput("clean_level_hi", 32'(level_o), 1);
    checkOutput("clean_count", 32'(press_count_o), 1);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 1);
    edgesUntil(1, 20, n);
    checkOutput("clean_release_lat", 32'(n), 7);
    checkOutput("clean_level_lo", 32'(level_o), 0);
    applyStimulus(1'b1, 6);

    $display("[TB] bounce");
    p0 = pressSeen;
    r0 = releaseSeen;
    for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? 1'b0 : 1'b1, 2);
    checkOutput("bounce_no_early_press", 32'(pressSeen - p0), 0);
    applyStimulus(1'b0, 1);
    edgesUntil(0, 20, n);
    checkOutput("bounce_press_lat", 32'(n), 7);
    applyStimulus(1'b0, 6);
    checkOutput("bounce_press_once", 32'(pressSeen - p0), 1);
    checkOutput("bounce_no_release", 32'(releaseSeen - r0), 0);
    applyStimulus(1'b1, 12);

    $display("[TB] long press");
    l0 = longSeen;
    applyStimulus(1'b0, 1);
    edgesUntil(0, 20, n);
    checkOutput("long_press_lat", 32'(n), 7);
    edgesUntil(2, 30, n);
    checkOutput("long_after_press", 32'(n), LONG_EN ? 20 : -1);
    r0 = releaseSeen;
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 20);
    checkOutput("long_glitch_no_release", 32'(releaseSeen - r0), 0);
    checkOutput("long_once", 32'(longSeen - l0), LONG_EN ? 1 : 0);
    applyStimulus(1'b1, 1);
    edgesUntil(1, 20, n);
    checkOutput("long_release_lat", 32'(n), 7);
    applyStimulus(1'b1, 6);

    $display("[TB] wrap");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 9);
      applyStimulus(1'b1, 9);
    end
    checkOutput("wrap_count", 32'(press_count_o), 17 % 16);

    $display("[TB] reset mid-debounce and mid-hold");
    applyStimulus(1'b0, 5);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_count", 32'(press_count_o), 0);
    checkOutput("rst_mid_level", 32'(level_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edgesUntil(0, 20, n);
    checkOutput("rst_mid_press_lat", 32'(n), 7);
    checkOutput("rst_mid_count_after", 32'(press_count_o), 1);
    applyStimulus(1'b0, 6);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_hold_level", 32'(level_o), 0);
    checkOutput("rst_hold_press", 32'(press_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 12);
    checkOutput("rst_hold_fresh_press", 32'(level_o), 1);
    applyStimulus(1'b1, 12);

    $display("[TB] random activity");
    for (int k = 0; k < 80; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    applyStimulus(1'b1, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Input-side conditioner for the icestick designs: turns a raw, bouncing push-button or PMOD switch into clean, single-cycle events. It sits between an input pin and the LED-pattern logic in `top`. It synchronises the pin, debounces it with a stable-time counter, and emits one-cycle press and release pulses, an optional long-press pulse, and a wrapping press counter.

## Interface
- `DEBOUNCE_CYCLES`, 12000: stable cycles needed to accept a level change (1 ms at 12 MHz); minimum 2.
- `LONG_CYCLES`, 6000000: cycles held in PRESSED before `long_o` fires (0.5 s); must be greater than `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, 1: 1 means the pin reads 0 when pressed; the pin is inverted after synchronisation.
- `clk` in 1: system clock, 12 MHz on the icestick.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_i` in 1: raw asynchronous pin.
- `level_o` out 1: debounced pressed level.
- `press_o` out 1: one-cycle pulse on an accepted press.
- `release_o` out 1: one-cycle pulse on an accepted release.
- `long_o` out 1: one-cycle pulse, at most once per press.
- `press_count_o` out 4: number of accepted presses, mod 16.

## Operation
- Synchroniser: two flops. Reset value is the "released" pin level, so it is 1 when `ACTIVE_LOW`=1.
- The FSM works on the synchronised, polarity-corrected signal `s`.
- RELEASED:
  - `s`=1 → PRESS_WAIT, debounce counter cleared.
- PRESS_WAIT:
  - `s`=0 → RELEASED. This is a glitch: no output.
  - Otherwise, when the counter reaches `DEBOUNCE_CYCLES`-1 → PRESSED. On this transition `press_o` pulses, `level_o` goes to 1, `press_count_o` increments and the hold counter clears.
  - Otherwise the counter increments.
- PRESSED:
  - `s`=0 → RELEASE_WAIT, debounce counter cleared.
  - Otherwise the hold counter increments and saturates.
  - `long_o` pulses once, when the hold counter reaches `LONG_CYCLES`-1 and the long flag is clear. The flag is then set.
- RELEASE_WAIT:
  - `s`=1 → PRESSED. The hold counter is not cleared and the long flag is kept.
  - Otherwise, when the counter reaches `DEBOUNCE_CYCLES`-1 → RELEASED. On this transition `release_o` pulses, `level_o` goes to 0 and the long flag clears.
  - Otherwise the counter increments.
- Counter widths: `$clog2` of the respective parameter. The counters never wrap, because each leaves its state at terminal count.
- `press_count_o`: 15 → 0 wraps silently.
- Asynchronous reset at any point, including mid-debounce or mid-hold:
  - state RELEASED, all counters 0, long flag cleared;
  - every output 0 while `rst_n` is low and on the first cycle after release.
- A pin held pressed through reset deassertion is reported as a fresh press after the normal latency.

## Timing
- All outputs are registered; there are no combinational paths from `btn_i`.
- Press latency: `press_o` is high exactly `DEBOUNCE_CYCLES`+3 rising edges after the first edge that samples the asserted pin. That is 2 synchroniser edges, 1 entry edge into PRESS_WAIT and `DEBOUNCE_CYCLES` counting edges.
- Release latency is the same: `DEBOUNCE_CYCLES`+3 edges.
- `level_o` changes on the same edge that the matching pulse asserts.
- `long_o` asserts `LONG_CYCLES` edges after `press_o`, provided the pin stays pressed and no release is accepted. Bounces shorter than the debounce time do not restart this timing.
- `press_o` and `release_o` are never high together. Minimum spacing between them is `DEBOUNCE_CYCLES`+1 cycles.

## Configuration
- `BTN_LONG_PRESS_EN` defined: the hold counter, long flag and `long_o` logic are built as described above.
- `BTN_LONG_PRESS_EN` undefined:
  - no hold counter or long flag is instantiated;
  - `long_o` is tied to 0;
  - `LONG_CYCLES` is ignored;
  - all other behaviour and timing are unchanged.

## Structure
- Shared package `btn_pkg`: FSM state encoding `btn_state_t` (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT) and a `BTN_CNT_W` helper function.
- One sub-module, `sync2`: a generic two-flop synchroniser with a reset-value parameter, reusable for other pins.

## Test plan
All runs use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20 and `ACTIVE_LOW`=1, with `BTN_LONG_PRESS_EN` defined unless stated.

- Clean press: `btn_i` goes 1→0 and holds → `press_o` is a single pulse 7 edges later, `level_o`=1, `press_count_o`=1. Release follows the same way → `release_o` 7 edges later, `level_o`=0.
- Bounce: `btn_i` toggles every 2 cycles for 12 cycles, then holds 0 → exactly one `press_o`, 7 edges after the final stable edge, and no `release_o`.
- Long press: hold 40 cycles → `long_o` pulses once, 20 edges after `press_o`. A 3-cycle glitch high during the hold produces no `release_o` and no second `long_o`.
- Wrap: 17 clean presses → `press_count_o` reads 1 at the end.
- Reset mid-debounce: assert `rst_n` low 2 cycles into PRESS_WAIT → all outputs 0 immediately. With the pin still low, `press_o` fires 7 edges after reset release.
- Macro off: the long-press run with `BTN_LONG_PRESS_EN` undefined → `long_o` stays 0 throughout, while `press_o` and `release_o` timing are identical to the macro-on run.
